// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: scan tick source, matrix lines and key outputs.
interface keypad_scan_if;
   logic       scan_clk;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   // Scanner side
   modport master (
      input  scan_clk,
      input  col_n,
      output row_n,
      output key_code,
      output key_valid,
      output key_down
   );

   // Board / alarm-controller side
   modport slave (
      output scan_clk,
      output col_n,
      input  row_n,
      input  key_code,
      input  key_valid,
      input  key_down
   );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner and debouncer. The divided scan clock is only
// sampled as a tick source; everything runs on Clock.
module keypad_scan #(
   parameter int unsigned DEB_TICKS = 20
) (
   input  logic          Clock,
   input  logic          Reset,
   keypad_scan_if.master kp
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_TICKS - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_t;

   state_t     state;
   logic       scan_s1;
   logic       scan_s2;
   logic       scan_s3;
   logic [1:0] prime;
   logic       armed;
   logic       tick;
   logic [3:0] col_s1;
   logic [3:0] col_s;
   logic [1:0] row_idx;
   logic [1:0] cap_idx;
   logic [3:0] cap_col;
   logic [7:0] deb_cnt;
   logic [3:0] row_n_q;
   logic [3:0] key_code_q;
   logic       key_valid_q;
   logic       key_down_q;
   logic [1:0] row_nxt;
   logic [3:0] row_adv_n;
   logic       col_idle;

   function automatic logic [1:0] low_col(input logic [3:0] c);
      logic [1:0] idx;
      if (!c[0])      idx = 2'd0;
      else if (!c[1]) idx = 2'd1;
      else if (!c[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

   // Synchronise scan_clk and columns; arm tick detection only once the
   // synchronised scan_clk has been seen low after reset, so a reset released
   // while scan_clk is high cannot fake a rising edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         scan_s1 <= 1'b0;
         scan_s2 <= 1'b0;
         scan_s3 <= 1'b0;
         prime   <= '0;
         armed   <= 1'b0;
         col_s1  <= '1;
         col_s   <= '1;
      end else begin
         scan_s1 <= kp.scan_clk;
         scan_s2 <= scan_s1;
         scan_s3 <= scan_s2;
         prime   <= {prime[0], 1'b1};
         armed   <= armed | (prime[1] & ~scan_s2);
         col_s1  <= kp.col_n;
         col_s   <= col_s1;
      end
   end

   // Tick strobe and next-row decode
   always_comb begin
      tick      = scan_s2 & ~scan_s3 & armed;
      row_nxt   = row_idx + 2'd1;
      row_adv_n = ~(4'b0001 << row_nxt);
      col_idle  = (col_s == 4'b1111);
   end

   // Scan / debounce state machine with registered outputs, advancing on ticks only
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= SCAN;
         row_idx     <= '0;
         cap_idx     <= '0;
         cap_col     <= '1;
         deb_cnt     <= '0;
         row_n_q     <= 4'b1110;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (col_idle) begin
                     row_idx <= row_nxt;
                     row_n_q <= row_adv_n;
                  end else begin
                     cap_col <= col_s;
                     cap_idx <= low_col(col_s);
                     deb_cnt <= '0;
                     state   <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (col_s == cap_col) begin
                     if (deb_cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        key_code_q  <= {row_idx, cap_idx};
                        key_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                     end else begin
                        deb_cnt <= deb_cnt + 8'd1;
                     end
                  end else begin
                     state   <= SCAN;
                     row_idx <= row_nxt;
                     row_n_q <= row_adv_n;
                  end
               end
               PRESSED: begin
                  if (col_idle) begin
                     deb_cnt <= '0;
                     state   <= RELEASE;
                  end
               end
               RELEASE: begin
                  if (col_idle) begin
                     if (deb_cnt == DEB_LAST) begin
                        state      <= SCAN;
                        row_idx    <= row_nxt;
                        row_n_q    <= row_adv_n;
                        key_down_q <= 1'b0;
                     end else begin
                        deb_cnt <= deb_cnt + 8'd1;
                     end
                  end else begin
                     state <= PRESSED;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   assign kp.row_n     = row_n_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model closes the row/column loop, expected
// key codes are queued at press time and matched against key_valid pulses.
module tb_keypad_scan;

   logic        Clock;
   logic        Reset;
   logic [15:0] km;
   logic [15:0] km1;
   int          n_checks;
   int          n_fail;
   logic [3:0]  q4[$];
   logic [3:0]  q1[$];
   logic        prev4;
   logic        prev1;

   keypad_scan_if kp4 ();
   keypad_scan_if kp1 ();

   keypad_scan #(.DEB_TICKS(4)) u_dut (
      .Clock (Clock),
      .Reset (Reset),
      .kp    (kp4)
   );

   keypad_scan #(.DEB_TICKS(1)) u_dut1 (
      .Clock (Clock),
      .Reset (Reset),
      .kp    (kp1)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Key m[r*4+c] pressed shorts row r to column c
   function automatic logic [3:0] kp_cols(input logic [3:0] rn, input logic [15:0] m);
      logic [3:0] c;
      c = '1;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned k = 0; k < 4; k++)
            if (m[r*4+k] && !rn[r]) c[k] = 1'b0;
      return c;
   endfunction

   assign kp4.col_n    = kp_cols(kp4.row_n, km);
   assign kp1.col_n    = kp_cols(kp1.row_n, km1);
   assign kp1.scan_clk = kp4.scan_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_tick();
      kp4.scan_clk = 1'b1;
      repeat (4) @(posedge Clock);
      #1;
      kp4.scan_clk = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
   endtask

   // Scoreboard: every key_valid pulse must be single-cycle and match a queued code
   always @(negedge Clock) begin
      if (kp4.key_valid) begin
         check_val("kv4_width", 32'(prev4), 0);
         check_val("kv4_expected", 32'(q4.size() != 0), 1);
         if (q4.size() != 0) check_val("key_code4", 32'(kp4.key_code), 32'(q4.pop_front()));
      end
      if (kp1.key_valid) begin
         check_val("kv1_width", 32'(prev1), 0);
         check_val("kv1_expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) check_val("key_code1", 32'(kp1.key_code), 32'(q1.pop_front()));
      end
      prev4 = kp4.key_valid;
      prev1 = kp1.key_valid;
   end

   initial begin
      logic [3:0] rows [4];
      rows[0] = 4'b1101; rows[1] = 4'b1011; rows[2] = 4'b0111; rows[3] = 4'b1110;
      n_checks = 0;
      n_fail   = 0;
      prev4    = 1'b0;
      prev1    = 1'b0;
      km       = '0;
      km1      = '0;
      Reset    = 1'b0;
      kp4.scan_clk = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      check_val("rst_row_n", 32'(kp4.row_n), 32'hE);
      check_val("rst_key_code", 32'(kp4.key_code), 0);
      check_val("rst_key_valid", 32'(kp4.key_valid), 0);
      check_val("rst_key_down", 32'(kp4.key_down), 0);
      Reset = 1'b1;
      repeat (6) @(posedge Clock);
      #1;

      // Idle scan walks the rows
      for (int unsigned i = 0; i < 4; i++) begin
         do_tick();
         check_val("idle_row_n", 32'(kp4.row_n), 32'(rows[i]));
      end

      // Press row 2 col 1: detected once row 2 is driven, accepted on 4th debounce tick
      km[9] = 1'b1;
      q4.push_back(4'd9);
      do_tick();
      do_tick();
      check_val("press_row_n", 32'(kp4.row_n), 32'hB);
      do_tick();
      check_val("deb_row_hold", 32'(kp4.row_n), 32'hB);
      for (int unsigned i = 1; i <= 3; i++) begin
         do_tick();
         check_val("deb_key_down_lo", 32'(kp4.key_down), 0);
      end
      do_tick();
      check_val("acc_key_down", 32'(kp4.key_down), 1);
      check_val("acc_key_code", 32'(kp4.key_code), 9);
      for (int unsigned i = 0; i < 5; i++) do_tick();
      check_val("held_row_n", 32'(kp4.row_n), 32'hB);
      check_val("held_key_down", 32'(kp4.key_down), 1);

      // Release with one re-press bounce, then a clean release
      km = '0;
      do_tick();
      check_val("rel1_key_down", 32'(kp4.key_down), 1);
      km[9] = 1'b1;
      do_tick();
      check_val("bounce_key_down", 32'(kp4.key_down), 1);
      km = '0;
      do_tick();
      for (int unsigned i = 1; i <= 3; i++) begin
         do_tick();
         check_val("rel_key_down_hi", 32'(kp4.key_down), 1);
      end
      do_tick();
      check_val("rel_key_down_lo", 32'(kp4.key_down), 0);
      check_val("rel_key_code", 32'(kp4.key_code), 9);
      check_val("rel_row_n", 32'(kp4.row_n), 32'h7);

      // Bounce during debounce: no acceptance, scan resumes at row 3
      do_tick();
      do_tick();
      do_tick();
      check_val("b_row_n", 32'(kp4.row_n), 32'hB);
      km[9] = 1'b1;
      do_tick();
      do_tick();
      km = '0;
      do_tick();
      check_val("b_resume_row_n", 32'(kp4.row_n), 32'h7);
      check_val("b_key_down", 32'(kp4.key_down), 0);

      // Row 0 with columns 1 and 3 low: lowest column wins
      km[1] = 1'b1;
      km[3] = 1'b1;
      q4.push_back(4'd1);
      do_tick();
      check_val("r0_row_n", 32'(kp4.row_n), 32'hE);
      for (int unsigned i = 0; i < 5; i++) do_tick();
      check_val("r0_key_code", 32'(kp4.key_code), 1);
      check_val("r0_key_down", 32'(kp4.key_down), 1);
      km = '0;
      for (int unsigned i = 0; i < 5; i++) do_tick();
      check_val("r0_rel_key_down", 32'(kp4.key_down), 0);
      check_val("r0_code_hold", 32'(kp4.key_code), 1);
      check_val("r0_rel_row_n", 32'(kp4.row_n), 32'hD);

      // Reset in DEBOUNCE with deb_cnt=2 discards the press
      km[6] = 1'b1;
      do_tick();
      do_tick();
      do_tick();
      Reset = 1'b0;
      #1;
      check_val("mid_rst_row_n", 32'(kp4.row_n), 32'hE);
      check_val("mid_rst_key_code", 32'(kp4.key_code), 0);
      check_val("mid_rst_key_down", 32'(kp4.key_down), 0);
      check_val("mid_rst_key_valid", 32'(kp4.key_valid), 0);
      km = '0;
      kp4.scan_clk = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b1;
      repeat (12) @(posedge Clock);
      #1;
      check_val("hi_rel_row_n", 32'(kp4.row_n), 32'hE);
      kp4.scan_clk = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      do_tick();
      check_val("first_edge_row_n", 32'(kp4.row_n), 32'hD);

      // DEB_TICKS=1: first matching debounce tick accepts
      km1[7] = 1'b1;
      q1.push_back(4'd7);
      do_tick();
      check_val("d1_key_down_lo", 32'(kp1.key_down), 0);
      do_tick();
      check_val("d1_key_down", 32'(kp1.key_down), 1);
      check_val("d1_key_code", 32'(kp1.key_code), 7);
      km1 = '0;
      repeat (4) @(posedge Clock);
      #1;

      check_val("q4_drained", 32'(q4.size()), 0);
      check_val("q1_drained", 32'(q1.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
